key_conditioner: RTL and testbench

- Front-end input stage feeding the stopwatch, timer and clock-set blocks.
- Synchronises and debounces the raw active-low push buttons.
- Classifies each press on KEY[1:0] as short or long.
- Owns the global display-mode register that downstream blocks compare against (timer active at mode==2).
- Replaces ad-hoc edge detection on raw KEY lines and per-block 2 s hold counters with clean single-cycle pulses on CLOCK_50.

---
 rtl/key_conditioner.sv | 125 ++++++++++++
 tb/tb_key_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces the active-low push buttons.
// Each debounced press on KEY[1:0] is classified as either short or long.
// KEY[2] steps the global display mode. Every output comes from a register,
// so none of them depends combinationally on KEY.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int NUM_MODES       = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [2:0] KEY,
  output logic [2:0] key_level,
  output logic [2:0] key_press,
  output logic [1:0] key_short,
  output logic [1:0] key_long,
  output logic [1:0] mode,
  output logic       mode_changed
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    MODE_LAST = 2'(NUM_MODES - 1);

  logic [2:0]    sync_p0;
  logic [2:0]    sync_p1;
  logic [2:0]    s;
  logic [DW-1:0] db_cnt [3];
  logic [2:0]    rise;
  logic [2:0]    fall;
  logic [HW-1:0] hold_cnt [2];
  logic [1:0]    armed;
  logic          mode_step;

  // Two-flop synchroniser on the raw lines. It resets to "released" (1).
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_p0 <= 3'b111;
      sync_p1 <= 3'b111;
    end else begin
      sync_p0 <= KEY;
      sync_p1 <= sync_p0;
    end
  end

  assign s = ~sync_p1;

  // A level change is accepted on the cycle the disagreement count completes.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < 3; i++) begin
      if (s[i] != key_level[i] && db_cnt[i] == DB_LAST) begin
        rise[i] = s[i];
        fall[i] = ~s[i];
      end
    end
  end

  assign mode_step = rise[2];

  // Debounce counters, the debounced level and the press pulses.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      key_level <= '0;
      key_press <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s[i] == key_level[i] || db_cnt[i] == DB_LAST)
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + DW'(1);
      end
      key_level <= (key_level | rise) & ~fall;
      key_press <= rise;
    end
  end

  // Mode register, stepped on each debounced KEY[2] press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode         <= '0;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= mode_step;
      if (mode_step)
        mode <= (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
    end
  end

  // Hold counting and short/long classification for KEY[1:0].
  // The armed bit marks a press that has not been classified yet.
  // A mode step clears it, so a press that spans a mode change reports nothing.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 2; i++) hold_cnt[i] <= '0;
      armed     <= '0;
      key_short <= '0;
      key_long  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mode_step) begin
          hold_cnt[i] <= '0;
          armed[i]    <= 1'b0;
        end else if (rise[i]) begin
          hold_cnt[i] <= '0;
          armed[i]    <= 1'b1;
        end else begin
          if (key_level[i] && hold_cnt[i] != HOLD_MAX)
            hold_cnt[i] <= hold_cnt[i] + HW'(1);
          if (fall[i] || (key_level[i] && hold_cnt[i] == HOLD_LAST))
            armed[i] <= 1'b0;
        end
        key_short[i] <= !mode_step && armed[i] && fall[i];
        key_long[i]  <= !mode_step && armed[i] && key_level[i] && !fall[i] &&
                        hold_cnt[i] == HOLD_LAST;
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed testbench for key_conditioner, using DEBOUNCE=4, HOLD=20, MODES=4.
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int HD = 20;
  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [1:0] key_short;
  logic [1:0] key_long;
  logic [1:0] mode;
  logic       mode_changed;

  int tests = 0;
  int fails = 0;
  int n_press [3] = '{0, 0, 0};
  int n_short [2] = '{0, 0};
  int n_long  [2] = '{0, 0};
  int n_mc = 0;
  int snap_a, snap_b;
  logic [1:0] exp_mode [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HD),
    .NUM_MODES      (NM)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .KEY         (key),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_short   (key_short),
    .key_long    (key_long),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) if (key_press[i]) n_press[i] <= n_press[i] + 1;
      for (int j = 0; j < 2; j++) begin
        if (key_short[j]) n_short[j] <= n_short[j] + 1;
        if (key_long[j])  n_long[j]  <= n_long[j] + 1;
      end
      if (mode_changed) n_mc <= n_mc + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 3'b111;
    tick(2);
    check("reset_level", 32'(key_level), 32'd0);
    check("reset_pulses", {key_press, key_short, key_long, mode_changed}, 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Clean 10-cycle press of KEY[0]
    snap_a = n_press[0];
    key[0] = 1'b0;
    tick(5);
    check("p0_level_early", 32'(key_level[0]), 32'd0);
    tick(1);
    check("p0_level_rise", 32'(key_level[0]), 32'd1);
    check("p0_press", 32'(key_press[0]), 32'd1);
    tick(1);
    check("p0_press_end", 32'(key_press[0]), 32'd0);
    tick(3);
    key[0] = 1'b1;
    tick(5);
    check("p0_short_early", 32'(key_short[0]), 32'd0);
    tick(1);
    check("p0_short", 32'(key_short[0]), 32'd1);
    check("p0_level_fall", 32'(key_level[0]), 32'd0);
    tick(2);
    check("p0_press_count", 32'(n_press[0] - snap_a), 32'd1);
    check("p0_short_count", 32'(n_short[0]), 32'd1);
    check("p0_long_count", 32'(n_long[0]), 32'd0);

    // KEY[1] held for 40 cycles
    key[1] = 1'b0;
    tick(6);
    check("p1_press", 32'(key_press[1]), 32'd1);
    tick(19);
    check("p1_long_early", 32'(key_long[1]), 32'd0);
    tick(1);
    check("p1_long", 32'(key_long[1]), 32'd1);
    tick(1);
    check("p1_long_end", 32'(key_long[1]), 32'd0);
    tick(13);
    key[1] = 1'b1;
    tick(5);
    check("p1_level_held", 32'(key_level[1]), 32'd1);
    tick(1);
    check("p1_level_fall", 32'(key_level[1]), 32'd0);
    check("p1_short_none", 32'(key_short[1]), 32'd0);
    tick(3);
    check("p1_long_count", 32'(n_long[1]), 32'd1);
    check("p1_short_count", 32'(n_short[1]), 32'd0);

    // Bouncing KEY[0]
    snap_a = n_press[0];
    for (int k = 0; k < 8; k++) begin
      key[0] = ~key[0];
      tick(2);
    end
    key[0] = 1'b0;
    tick(5);
    check("bounce_no_press", 32'(n_press[0] - snap_a), 32'd0);
    check("bounce_level_low", 32'(key_level[0]), 32'd0);
    tick(1);
    check("bounce_press", 32'(key_press[0]), 32'd1);
    tick(2);
    check("bounce_press_count", 32'(n_press[0] - snap_a), 32'd1);
    key[0] = 1'b1;
    tick(9);

    // Five KEY[2] presses step the mode
    snap_a = n_mc;
    for (int k = 0; k < 5; k++) begin
      key[2] = 1'b0;
      tick(6);
      check("mode_press", 32'(key_press[2]), 32'd1);
      check("mode_changed", 32'(mode_changed), 32'd1);
      check("mode_value", 32'(mode), 32'(exp_mode[k]));
      key[2] = 1'b1;
      tick(8);
    end
    check("mode_changed_count", 32'(n_mc - snap_a), 32'd5);

    // A mode change during a KEY[1] hold cancels its classification
    snap_a = n_long[1];
    snap_b = n_short[1];
    key[1] = 1'b0;
    tick(6);
    check("cancel_press", 32'(key_press[1]), 32'd1);
    tick(10);
    key[2] = 1'b0;
    tick(6);
    check("cancel_mode_changed", 32'(mode_changed), 32'd1);
    check("cancel_mode", 32'(mode), 32'd2);
    key[2] = 1'b1;
    tick(30);
    key[1] = 1'b1;
    tick(8);
    check("cancel_no_long", 32'(n_long[1] - snap_a), 32'd0);
    check("cancel_no_short", 32'(n_short[1] - snap_b), 32'd0);

    // Reset while KEY[0] is held with the mode at 3
    key[2] = 1'b0;
    tick(6);
    check("pre_reset_mode", 32'(mode), 32'd3);
    key[2] = 1'b1;
    tick(8);
    key[0] = 1'b0;
    tick(10);
    check("pre_reset_level", 32'(key_level[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_mode", 32'(mode), 32'd0);
    check("midreset_outputs",
          {key_level, key_press, key_short, key_long, mode_changed}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rel_press_early", 32'(key_press[0]), 32'd0);
    tick(1);
    check("rel_press", 32'(key_press[0]), 32'd1);
    check("rel_level", 32'(key_level[0]), 32'd1);
    check("rel_mode", 32'(mode), 32'd0);
    key[0] = 1'b1;
    tick(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
